// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared encodings for the multicycle controller: FSM state type, instruction
// op and cmd codes, ALU control codes and datapath mux-select constants.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } ctrl_state_t;

    // instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic       SRCA_RN = 1'b0;
    localparam logic       SRCA_PC = 1'b1;

    localparam logic [1:0] SRCB_RM     = 2'd0;
    localparam logic [1:0] SRCB_EXTIMM = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT   = 2'd0;
    localparam logic [1:0] RES_READDATA = 2'd1;
    localparam logic [1:0] RES_ALU      = 2'd2;

    // CMP only sets flags; it never writes a register.
    function automatic logic is_cmp(input logic [3:0] cmd);
        return cmd == CMD_CMP;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Maps the data-processing cmd and S bit onto the ALU operation and the raw
// flag-write intent. Outside the execute states (exec=0) it yields ADD and no
// flag writes.
// Ports:
//   cmd         in  4  instr[24:21]
//   s           in  1  S bit (instr[20])
//   exec        in  1  controller is in EXECR or EXECI
//   alu_control out 2  ALU operation
//   flag_w      out 2  [1]=NZ, [0]=CV write intent
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       exec,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w
);

    logic sets_flags;
    logic arith;

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        sets_flags  = s | is_cmp(cmd);
        arith       = (cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP);
        if (exec) begin
            unique case (cmd)
                CMD_ADD: alu_control = ALU_ADD;
                CMD_SUB: alu_control = ALU_SUB;
                CMD_CMP: alu_control = ALU_SUB;
                CMD_AND: alu_control = ALU_AND;
                CMD_ORR: alu_control = ALU_ORR;
                default: alu_control = ALU_ADD;
            endcase
            // Logic ops leave C/V untouched.
            flag_w = {sets_flags, sets_flags & arith};
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM of the multicycle ARM-subset core. Walks each instruction
// through fetch/decode/execute/memory/writeback and emits ungated control
// intents (pcs, reg_w, mem_w, flag_w) plus datapath selects and enables.
// Outputs are Moore: decoded from the state register and the held
// instruction fields, and forced to 0 while rst_n is low.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op, funct, rd         instruction fields (stable from DECODE to FETCH)
//   pcs, reg_w, mem_w     raw write intents
//   flag_w                raw flag-write intent [1]=NZ [0]=CV
//   next_pc, ir_write     fetch-time PC increment and IR load
//   adr_src, alu_src_a,
//   alu_src_b, result_src datapath mux selects
//   alu_control           ALU operation
//
// Handshake: none. The controller free-runs one state per clock; the
// instruction fields are assumed valid and stable whenever they are sampled.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic [1:0] flag_w,
    output logic       next_pc,
    output logic       ir_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_control
);

    ctrl_state_t state;

    logic       exec;
    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       rd_is_pc;

    assign exec     = (state == S_EXECR) || (state == S_EXECI);
    assign rd_is_pc = (rd == 4'd15);

    alu_decoder u_alu_decoder (
        .cmd         (funct[4:1]),
        .s           (funct[0]),
        .exec        (exec),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    unique case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;   // illegal op: drop it
                    endcase
                end
                S_MEMADR: state <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXECR,
                S_EXECI:  state <= S_ALUWB;
                default:  state <= S_FETCH;          // MEMWB, MEMWR, ALUWB, BRANCH
            endcase
        end
    end

    always_comb begin
        pcs         = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        flag_w      = 2'b00;
        next_pc     = 1'b0;
        ir_write    = 1'b0;
        adr_src     = ADR_PC;
        alu_src_a   = SRCA_RN;
        alu_src_b   = SRCB_RM;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                // PC+8 for R15 reads
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RN;
                alu_src_b = SRCB_EXTIMM;
            end
            S_MEMRD: begin
                adr_src    = ADR_ALUOUT;
                result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src = RES_READDATA;
                reg_w      = 1'b1;
                pcs        = rd_is_pc;
            end
            S_MEMWR: begin
                adr_src = ADR_ALUOUT;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RN;
                alu_src_b   = SRCB_RM;
                alu_control = dec_alu_control;
                flag_w      = dec_flag_w;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RN;
                alu_src_b   = SRCB_EXTIMM;
                alu_control = dec_alu_control;
                flag_w      = dec_flag_w;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w      = !is_cmp(funct[4:1]);
                pcs        = rd_is_pc && !is_cmp(funct[4:1]);
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RN;
                alu_src_b  = SRCB_EXTIMM;
                result_src = RES_ALU;
                pcs        = 1'b1;
            end
            default: ;
        endcase

        // Reset silences every output at once, including mid-instruction.
        if (!rst_n) begin
            pcs         = 1'b0;
            reg_w       = 1'b0;
            mem_w       = 1'b0;
            flag_w      = 2'b00;
            next_pc     = 1'b0;
            ir_write    = 1'b0;
            adr_src     = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            result_src  = 2'b00;
            alu_control = 2'b00;
        end
    end

endmodule
